// File: rtl/mips_pkg.sv
// Shared constants and types for the MIPS register file and its read ports.
package mips_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] word_t;

endpackage

// File: rtl/mips_regfile_rdport.sv
// One combinational read port: address decode, AND-OR select, $0/reset force-to-zero.
// Optional write-before-read bypass when MIPS_REGFILE_WRITE_BYPASS_EN is defined.
module mips_regfile_rdport #(
    parameter int DATA_W = mips_pkg::DATA_W,
    parameter int ADDR_W = mips_pkg::ADDR_W
) (
    input  logic                                rst_n,
    input  logic [ADDR_W-1:0]                   raddr,
    input  logic [2**ADDR_W-1:0][DATA_W-1:0]    regs,
    output logic [DATA_W-1:0]                   rdata
`ifdef MIPS_REGFILE_WRITE_BYPASS_EN
    ,
    input  logic                                byp_valid,
    input  logic [ADDR_W-1:0]                   byp_addr,
    input  logic [DATA_W-1:0]                   byp_data
`endif
);
    import mips_pkg::*;

    localparam int NREGS = 2**ADDR_W;

    logic [NREGS-1:0]  hit;
    logic [DATA_W-1:0] sel_data;
    logic              is_zero;

    genvar gi;
    generate
        for (gi = 0; gi < NREGS; gi++) begin : g_decode
            assign hit[gi] = (raddr == ADDR_W'(gi));
        end
    endgenerate

    assign is_zero = (raddr == ADDR_W'(REG_ZERO));

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NREGS; i++) begin
            sel_data = sel_data | (regs[i] & {DATA_W{hit[i]}});
        end
    end

    // Zero/reset force is applied last so it dominates the bypass path as well.
    always_comb begin
        rdata = sel_data;
`ifdef MIPS_REGFILE_WRITE_BYPASS_EN
        if (byp_valid && (raddr == byp_addr)) begin
            rdata = byp_data;
        end
`endif
        if (!rst_n || is_zero) begin
            rdata = '0;
        end
    end

endmodule

// File: rtl/mips_regfile.sv
// 32x32 MIPS register file: one write port, two combinational read ports, $0 hardwired to zero.
// Build option MIPS_REGFILE_WRITE_BYPASS_EN enables same-cycle write-to-read forwarding.
module mips_regfile #(
    parameter int DATA_W = mips_pkg::DATA_W,
    parameter int ADDR_W = mips_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2
);
    import mips_pkg::*;

    localparam int NREGS = 2**ADDR_W;

    logic                           wr_valid;
    logic [NREGS-1:1]               wr_sel;
    logic [NREGS-1:0][DATA_W-1:0]   regs_flat;

    // we gates first so an X address/data with we=0 cannot reach any enable.
    assign wr_valid = we && rst_n && (waddr != ADDR_W'(REG_ZERO));

    assign regs_flat[0] = '0;

    genvar gi;
    generate
        for (gi = 1; gi < NREGS; gi++) begin : g_reg
            logic [DATA_W-1:0] reg_q;
            logic [DATA_W-1:0] reg_d;

            assign wr_sel[gi] = wr_valid && (waddr == ADDR_W'(gi));

            always_comb begin
                reg_d = reg_q;
                if (wr_sel[gi]) begin
                    reg_d = wdata;
                end
            end

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    reg_q <= '0;
                end else begin
                    reg_q <= reg_d;
                end
            end

            assign regs_flat[gi] = reg_q;
        end
    endgenerate

    mips_regfile_rdport #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_rdport1 (
        .rst_n     (rst_n),
        .raddr     (raddr1),
        .regs      (regs_flat),
        .rdata     (rdata1)
`ifdef MIPS_REGFILE_WRITE_BYPASS_EN
        ,
        .byp_valid (wr_valid),
        .byp_addr  (waddr),
        .byp_data  (wdata)
`endif
    );

    mips_regfile_rdport #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_rdport2 (
        .rst_n     (rst_n),
        .raddr     (raddr2),
        .regs      (regs_flat),
        .rdata     (rdata2)
`ifdef MIPS_REGFILE_WRITE_BYPASS_EN
        ,
        .byp_valid (wr_valid),
        .byp_addr  (waddr),
        .byp_data  (wdata)
`endif
    );

endmodule

// File: tb/tb_mips_regfile.sv
// Directed self-checking bench for mips_regfile; expected values are hand-computed constants.
module tb_mips_regfile;
    import mips_pkg::*;

    logic      clk;
    logic      rst_n;
    logic      we;
    reg_addr_t waddr;
    word_t     wdata;
    reg_addr_t raddr1;
    reg_addr_t raddr2;
    word_t     rdata1;
    word_t     rdata2;

    int vectors;
    int miscompares;

    mips_regfile dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .we     (we),
        .waddr  (waddr),
        .wdata  (wdata),
        .raddr1 (raddr1),
        .raddr2 (raddr2),
        .rdata1 (rdata1),
        .rdata2 (rdata2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input word_t observed, input word_t expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
        $display("vec %0d %s observed=%h expected=%h", vectors, tag, observed, expected);
    endtask

    // Advance past the next rising edge; inputs then change at edge+1, checks at edge+2.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;

        // Reset held two cycles while a write is presented.
        rst_n  = 1'b0;
        we     = 1'b1;
        waddr  = 5'd5;
        wdata  = 32'hDEADBEEF;
        raddr1 = 5'd5;
        raddr2 = 5'd0;
        #1;
        check("during_reset_r5", rdata1, 32'h0);
        tick();
        tick();
        #1;
        check("reset_r5_held", rdata1, 32'h0);
        rst_n = 1'b1;
        we    = 1'b0;
        #1;
        check("after_reset_r5", rdata1, 32'h0);
        for (int i = 0; i < 32; i++) begin
            raddr2 = reg_addr_t'(i);
            #1;
            check($sformatf("reset_scan_r%0d", i), rdata2, 32'h0);
        end

        // Basic write then read on both ports.
        we    = 1'b1;
        waddr = 5'd8;
        wdata = 32'h12345678;
        tick();
        we     = 1'b0;
        raddr1 = 5'd8;
        raddr2 = 5'd8;
        #1;
        check("r8_port1", rdata1, 32'h12345678);
        check("r8_port2", rdata2, 32'h12345678);

        // Write to $0 is discarded, including on the same-cycle read.
        we     = 1'b1;
        waddr  = 5'd0;
        wdata  = 32'hFFFFFFFF;
        raddr1 = 5'd0;
        #1;
        check("r0_same_cycle", rdata1, 32'h0);
        tick();
        we = 1'b0;
        #1;
        check("r0_after_write", rdata1, 32'h0);
        check("r8_untouched_by_r0", rdata2, 32'h12345678);

        // Two independent ports on different registers.
        we    = 1'b1;
        waddr = 5'd3;
        wdata = 32'hA5A5A5A5;
        tick();
        waddr = 5'd31;
        wdata = 32'h0000FFFF;
        tick();
        we     = 1'b0;
        raddr1 = 5'd3;
        raddr2 = 5'd31;
        #1;
        check("dual_r3", rdata1, 32'hA5A5A5A5);
        check("dual_r31", rdata2, 32'h0000FFFF);

        // Same-cycle read of the write target.
        we    = 1'b1;
        waddr = 5'd9;
        wdata = 32'd1;
        tick();
        waddr  = 5'd9;
        wdata  = 32'd2;
        raddr1 = 5'd9;
        raddr2 = 5'd3;
        #1;
`ifdef MIPS_REGFILE_WRITE_BYPASS_EN
        check("r9_same_cycle", rdata1, 32'd2);
`else
        check("r9_same_cycle", rdata1, 32'd1);
`endif
        check("r3_other_port", rdata2, 32'hA5A5A5A5);
        tick();
        we = 1'b0;
        #1;
        check("r9_next_cycle", rdata1, 32'd2);

        // Consecutive writes to one address: last wins.
        we    = 1'b1;
        waddr = 5'd10;
        wdata = 32'h0000AAAA;
        tick();
        wdata = 32'h0000BBBB;
        tick();
        we     = 1'b0;
        raddr1 = 5'd10;
        #1;
        check("r10_last_wins", rdata1, 32'h0000BBBB);

        // we=0 leaves state alone.
        waddr = 5'd3;
        wdata = 32'h0;
        tick();
        raddr1 = 5'd3;
        #1;
        check("r3_no_we", rdata1, 32'hA5A5A5A5);

        // Reset mid-operation drops the concurrent write and clears everything.
        we    = 1'b1;
        waddr = 5'd4;
        wdata = 32'd7;
        tick();
        we     = 1'b0;
        raddr1 = 5'd4;
        #1;
        check("r4_before_reset", rdata1, 32'd7);
        rst_n = 1'b0;
        we    = 1'b1;
        waddr = 5'd4;
        wdata = 32'd9;
        tick();
        rst_n  = 1'b1;
        we     = 1'b0;
        waddr  = 'x;
        wdata  = 'x;
        raddr2 = 5'd31;
        #1;
        check("r4_after_reset", rdata1, 32'h0);
        check("r31_after_reset", rdata2, 32'h0);
        for (int c = 0; c < 3; c++) begin
            tick();
            #1;
            check($sformatf("r4_x_idle_%0d", c), rdata1, 32'h0);
        end

        // Normal writes resume after reset.
        we    = 1'b1;
        waddr = 5'd4;
        wdata = 32'h00000055;
        tick();
        we = 1'b0;
        #1;
        check("r4_resume", rdata1, 32'h00000055);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
